// File: rtl/song_sequencer_pkg.sv
// Shared encodings for the song sequencer: global mode values, sequencer states
// and the ROM-word sentinels (rest note, end-of-song duration).
package song_sequencer_pkg;

   localparam logic [1:0] PLAY_MODE = 2'd1;
   localparam logic [1:0] UART_MODE = 2'd2;

   localparam int REST_NOTE = 0;
   localparam int END_DUR   = 0;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_FETCH,
      SEQ_WAIT,
      SEQ_LOAD,
      SEQ_PLAY,
      SEQ_PAUSED,
      SEQ_DONE
   } seq_state_e;

   // Auto-play only owns the buzzer outside of live-play and UART modes.
   function automatic logic seq_enabled(input logic [1:0] mode);
      return (mode != PLAY_MODE) && (mode != UART_MODE);
   endfunction

endpackage

// File: rtl/song_sequencer_tick_timer.sv
// Note-duration timer: a TICK_DIV prescaler feeding a duration down-counter.
// load restarts a note, hold freezes both counters, expire marks a note's last cycle.
module seq_tick_timer #(
   parameter int TICK_DIV = 12_500_000,
   parameter int DUR_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             hold,
   input  logic [DUR_W-1:0] dur,
   output logic             expire
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   logic [TW-1:0]    tick_cnt;
   logic [DUR_W-1:0] dur_cnt;
   logic             wrap;

   assign wrap   = (tick_cnt == TICK_MAX);
   assign expire = wrap && (dur_cnt == DUR_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         dur_cnt  <= '0;
      end else if (load) begin
         tick_cnt <= '0;
         dur_cnt  <= dur;
      end else if (!hold) begin
         if (wrap) begin
            tick_cnt <= '0;
            if (dur_cnt != '0) dur_cnt <= dur_cnt - 1'b1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/song_sequencer.sv
// Auto-play song sequencer: walks a song's {note, dur} words in the song ROM and
// times each note. Define SEQ_LOOP_EN to replay the song instead of returning to idle.
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter int SONG_W   = 5,
   parameter int OFF_W    = 6,
   parameter int NOTE_W   = 5,
   parameter int DUR_W    = 4,
   parameter int TICK_DIV = 12_500_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic [SONG_W-1:0]        song_idx,
   input  logic                     select,
   input  logic                     pause,
   input  logic                     stop,
   output logic [SONG_W+OFF_W-1:0]  rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]  rom_data,
   output logic [NOTE_W-1:0]        note,
   output logic                     note_valid,
   output logic                     busy,
   output logic                     done
);

   localparam logic [OFF_W-1:0] OFF_MAX = {OFF_W{1'b1}};

   seq_state_e              state, state_n;
   logic                    select_q;
   logic [SONG_W-1:0]       cur_song, cur_song_n;
   logic [OFF_W-1:0]        off, off_n, off_inc;
   logic [SONG_W+OFF_W-1:0] rom_addr_n;
   logic [NOTE_W-1:0]       note_n, rd_note;
   logic [DUR_W-1:0]        rd_dur;
   logic                    note_valid_n;
   logic                    sel_edge, abort;
   logic                    tmr_load, tmr_hold, tmr_expire;

   assign rd_note  = rom_data[NOTE_W+DUR_W-1 -: NOTE_W];
   assign rd_dur   = rom_data[DUR_W-1:0];
   assign off_inc  = off + 1'b1;
   assign sel_edge = select && !select_q;
   assign abort    = stop || !seq_enabled(mode);
   assign busy     = (state != SEQ_IDLE);
   assign done     = (state == SEQ_DONE);

   seq_tick_timer #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .hold   (tmr_hold),
      .dur    (rd_dur),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SEQ_IDLE;
         select_q   <= 1'b0;
         cur_song   <= '0;
         off        <= '0;
         rom_addr   <= '0;
         note       <= '0;
         note_valid <= 1'b0;
      end else begin
         state      <= state_n;
         select_q   <= select;
         cur_song   <= cur_song_n;
         off        <= off_n;
         rom_addr   <= rom_addr_n;
         note       <= note_n;
         note_valid <= note_valid_n;
      end
   end

   always_comb begin
      state_n      = state;
      cur_song_n   = cur_song;
      off_n        = off;
      rom_addr_n   = rom_addr;
      note_n       = note;
      note_valid_n = note_valid;
      tmr_load     = 1'b0;
      tmr_hold     = 1'b1;

      if (abort) begin
         state_n      = SEQ_IDLE;
         note_valid_n = 1'b0;
      end else if (sel_edge) begin
         state_n      = SEQ_FETCH;
         cur_song_n   = song_idx;
         off_n        = '0;
         rom_addr_n   = {song_idx, {OFF_W{1'b0}}};
         note_valid_n = 1'b0;
      end else begin
         unique case (state)
            SEQ_FETCH: state_n = SEQ_WAIT;
            SEQ_WAIT:  state_n = SEQ_LOAD;
            SEQ_LOAD: begin
               if (rd_dur == DUR_W'(END_DUR)) begin
                  state_n = SEQ_DONE;
               end else begin
                  tmr_load     = 1'b1;
                  note_n       = rd_note;
                  note_valid_n = (rd_note != NOTE_W'(REST_NOTE));
                  state_n      = SEQ_PLAY;
               end
            end
            SEQ_PLAY: begin
               if (pause) begin
                  state_n      = SEQ_PAUSED;
                  note_valid_n = 1'b0;
               end else begin
                  tmr_hold = 1'b0;
                  if (tmr_expire) begin
                     note_valid_n = 1'b0;
                     // A full song slot with no end marker finishes instead of wrapping.
                     if (off == OFF_MAX) begin
                        state_n = SEQ_DONE;
                     end else begin
                        off_n      = off_inc;
                        rom_addr_n = {cur_song, off_inc};
                        state_n    = SEQ_WAIT;
                     end
                  end
               end
            end
            SEQ_PAUSED: begin
               if (!pause) begin
                  state_n      = SEQ_PLAY;
                  note_valid_n = (note != NOTE_W'(REST_NOTE));
               end
            end
            SEQ_DONE: begin
`ifdef SEQ_LOOP_EN
               off_n      = '0;
               rom_addr_n = {cur_song, {OFF_W{1'b0}}};
               state_n    = SEQ_FETCH;
`else
               state_n    = SEQ_IDLE;
`endif
            end
            default: state_n = SEQ_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer with TICK_DIV=4 and a registered song ROM model.
module tb_song_sequencer;
   import song_sequencer_pkg::*;

   localparam int TD   = 4;
   localparam int MAXC = 512;

   logic        clk = 1'b0;
   logic        rst, select, pause, stop;
   logic [1:0]  mode;
   logic [4:0]  song_idx;
   logic [10:0] rom_addr;
   logic [8:0]  rom_data;
   logic [4:0]  note;
   logic        note_valid, busy, done;

   logic [8:0]  rom [0:2047];
   int          checks = 0;
   int          errors = 0;

   logic        m_nv   [0:MAXC];
   logic        m_busy [0:MAXC];
   logic        m_done [0:MAXC];
   logic [4:0]  m_note [0:MAXC];

   song_sequencer #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .song_idx   (song_idx),
      .select     (select),
      .pause      (pause),
      .stop       (stop),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .note       (note),
      .note_valid (note_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic set_word(input int song, input int off, input int n, input int d);
      rom[song*64 + off] = {n[4:0], d[3:0]};
   endtask

   // Expected per-cycle outputs for one playback, indexed from the select-edge cycle (0):
   // first word is in LOAD at cycle 3, each note sounds dur*TD cycles, next word's LOAD
   // follows two cycles after a note ends, an end marker or word 63 leads to one done cycle.
   task automatic build_model(input int song, input int ncyc);
      int load, off, d, endc, stop_at;
      logic [4:0] n;
      logic [8:0] w;
      bit ended;
      for (int i = 0; i <= ncyc; i++) begin
         m_nv[i] = 1'b0; m_busy[i] = 1'b1; m_done[i] = 1'b0; m_note[i] = '0;
      end
      load = 3; off = 0; stop_at = -1;
      while (load <= ncyc && stop_at < 0) begin
         w = rom[song*64 + off];
         n = w[8:4];
         d = int'(w[3:0]);
         if (d == 0) begin
            endc  = load;
            ended = 1'b1;
         end else begin
            for (int c = load + 1; c <= load + d*TD && c <= ncyc; c++) begin
               m_nv[c] = (n != 5'd0); m_note[c] = n;
            end
            endc  = load + d*TD;
            ended = (off == 63);
         end
         if (!ended) begin
            off++;
            load = endc + 2;
         end else begin
            if (endc + 1 <= ncyc) m_done[endc + 1] = 1'b1;
`ifdef SEQ_LOOP_EN
            off  = 0;
            load = endc + 4;
`else
            stop_at = endc + 2;
`endif
         end
      end
      if (stop_at >= 0)
         for (int c = stop_at; c <= ncyc; c++) m_busy[c] = 1'b0;
   endtask

   task automatic play_and_check(input int song, input int ncyc, input string tag);
      build_model(song, ncyc);
      song_idx = song[4:0];
      select   = 1'b1;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         select = 1'b0;
         checks++;
         if (note_valid !== m_nv[i]) begin
            errors++;
            $display("FAIL %s cyc %0d note_valid got %b exp %b", tag, i, note_valid, m_nv[i]);
         end
         checks++;
         if (busy !== m_busy[i]) begin
            errors++;
            $display("FAIL %s cyc %0d busy got %b exp %b", tag, i, busy, m_busy[i]);
         end
         checks++;
         if (done !== m_done[i]) begin
            errors++;
            $display("FAIL %s cyc %0d done got %b exp %b", tag, i, done, m_done[i]);
         end
         if (m_nv[i]) begin
            checks++;
            if (note !== m_note[i]) begin
               errors++;
               $display("FAIL %s cyc %0d note got %0d exp %0d", tag, i, note, m_note[i]);
            end
         end
      end
   endtask

   task automatic idle_out();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rom_addr !== 11'd0 || note !== 5'd0 || note_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs got addr=%0d note=%0d nv=%b busy=%b done=%b exp all 0",
                  rom_addr, note, note_valid, busy, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      set_word(2, 0, 1, 2);
      set_word(2, 1, 0, 1);
      set_word(2, 2, 0, 0);
      play_and_check(2, 45, "basic");
      idle_out();
   endtask

   task automatic test_random_songs();
      for (int s = 0; s < 4; s++) begin
         int song, len;
         song = int'($urandom_range(0, 31));
         len  = int'($urandom_range(1, 5));
         for (int k = 0; k < len; k++)
            set_word(song, k, int'($urandom_range(0, 31)), int'($urandom_range(1, 3)));
         set_word(song, len, int'($urandom_range(0, 31)), 0);
         play_and_check(song, 90, "random");
         idle_out();
      end
   endtask

   task automatic test_pause();
      int  run;
      bit  fin, seen;
      set_word(7, 0, 9, 3);
      set_word(7, 1, 0, 0);
      song_idx = 5'd7;
      select   = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         select = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (note_valid !== 1'b1) begin
         errors++;
         $display("FAIL pause_pre note_valid got %b exp 1", note_valid);
      end
      pause = 1'b1;
      for (int i = 15; i <= 19; i++) begin
         @(negedge clk);
         checks++;
         if (note_valid !== 1'b0 || note !== 5'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL paused cyc %0d got nv=%b note=%0d busy=%b exp nv=0 note=9 busy=1",
                     i, note_valid, note, busy);
         end
      end
      pause = 1'b0;
      run = 0; fin = 1'b0;
      for (int k = 0; k < 20 && !fin; k++) begin
         @(negedge clk);
         if (note_valid) run++;
         else fin = 1'b1;
      end
      checks++;
      if (!fin || run != 3*TD - 10) begin
         errors++;
         $display("FAIL pause_resume run got %0d (ended=%b) exp %0d", run, fin, 3*TD - 10);
      end
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL pause_done got no done pulse exp one");
      end
      @(negedge clk);
      checks++;
`ifdef SEQ_LOOP_EN
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL pause_busy got %b exp 1", busy);
      end
`else
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL pause_busy got %b exp 0", busy);
      end
`endif
      idle_out();
   endtask

   task automatic test_stop();
      int dn;
      set_word(9, 0, 3, 3);
      set_word(9, 1, 4, 2);
      set_word(9, 2, 0, 0);
      song_idx = 5'd9;
      select   = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         select = 1'b0;
      end
      checks++;
      if (note_valid !== 1'b1) begin
         errors++;
         $display("FAIL stop_pre note_valid got %b exp 1", note_valid);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || note_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL stop got busy=%b nv=%b done=%b exp 0 0 0", busy, note_valid, done);
      end
      dn = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      checks++;
      if (dn != 0) begin
         errors++;
         $display("FAIL stop_after got %0d active cycles exp 0", dn);
      end
   endtask

   task automatic test_restart_abort();
      set_word(2, 0, 1, 2);
      set_word(2, 1, 0, 1);
      set_word(2, 2, 0, 0);
      set_word(5, 0, 6, 1);
      set_word(5, 1, 0, 0);
      song_idx = 5'd2;
      select   = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         select = 1'b0;
      end
      song_idx = 5'd5;
      select   = 1'b1;
      @(negedge clk);
      select = 1'b0;
      checks++;
      if (rom_addr !== {5'd5, 6'd0} || busy !== 1'b1) begin
         errors++;
         $display("FAIL restart got addr=%0d busy=%b exp addr=%0d busy=1", rom_addr, busy, {5'd5, 6'd0});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (note_valid !== 1'b1 || note !== 5'd6) begin
         errors++;
         $display("FAIL restart_note got nv=%b note=%0d exp nv=1 note=6", note_valid, note);
      end
      mode = PLAY_MODE;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || note_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mode_abort got busy=%b nv=%b done=%b exp 0 0 0", busy, note_valid, done);
      end
      select = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL disabled_select busy got %b exp 0", busy);
      end
      select = 1'b0;
      mode   = 2'd0;
      @(negedge clk);
      select = 1'b1;
      @(negedge clk);
      select = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reenable_start busy got %b exp 1", busy);
      end
      mode = UART_MODE;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL uart_abort busy got %b exp 0", busy);
      end
      mode = 2'd0;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 64; k++) set_word(11, k, int'($urandom_range(0, 31)), 1);
      play_and_check(11, 392, "wrap");
      idle_out();
   endtask

   task automatic test_reset_mid();
      song_idx = 5'd9;
      select   = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         select = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (rom_addr !== 11'd0 || note !== 5'd0 || note_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got addr=%0d note=%0d nv=%b busy=%b done=%b exp all 0",
                  rom_addr, note, note_valid, busy, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; select = 1'b0; pause = 1'b0; stop = 1'b0;
      mode = 2'd0; song_idx = '0;
      for (int i = 0; i < 2048; i++) rom[i] = '0;
      test_reset();
      test_basic();
      test_random_songs();
      test_pause();
      test_stop();
      test_restart_abort();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
